// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stop levels, exception codes,
// sequencer state encodings and the stall-vector encoder.
package pipe_ctrl_pkg;

    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_STALL    = 2'd1,
        PC_EXC_HOLD = 2'd2,
        PC_FLUSH    = 2'd3
    } pc_state_e;

    // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    function automatic logic [5:0] stall_encode(input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        logic [5:0] enc;
        if (req_mem)     enc = STALL_MEM;
        else if (req_ex) enc = STALL_EX;
        else if (req_id) enc = STALL_ID;
        else             enc = STALL_NONE;
        return enc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Sequencer bus: per-stage stall requests and exception info in, stall/flush
// control, redirect PC and stall statistics out.
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at MAX; clr wins over inc. sat is high while the
// count sits at MAX.
module sat_counter #(
    parameter int             W   = 32,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && !sat)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign sat   = (count_q == MAX);
    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences exception flushes
// with the redirect PC, and keeps stall statistics plus a sticky hang watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam int         WD_W       = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    pc_state_e   state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        flush_q, flush_d;
    logic        stall_timeout_q, stall_timeout_d;
    logic [5:0]  stall_d;

    logic            exc_req;
    logic            any_req;
    logic            stall_any;
    logic [WD_W-1:0] wd_count;
    logic            wd_sat;
    logic [31:0]     cycles_count;
    logic            cycles_sat;

    assign exc_req = (bus.excepttype_i != ZERO_WORD);
    assign any_req = bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;

    // The exception cycle itself acts as the hold cycle (wb retires, everything
    // upstream stops), so RUN/STALL jump straight to FLUSH and new_pc latches on
    // that edge. EXC_HOLD is only reachable as a recovery path.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        new_pc_d    = new_pc_q;
        stall_d     = STALL_NONE;
        case (state_q)
            PC_RUN, PC_STALL: begin
                if (exc_req) begin
                    stall_d     = STALL_MEM;
                    state_d     = PC_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                    new_pc_d    = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i
                                                                 : EXC_VECTOR;
                end else begin
                    stall_d = stall_encode(bus.stallreq_id, bus.stallreq_ex,
                                           bus.stallreq_mem);
                    state_d = any_req ? PC_STALL : PC_RUN;
                end
            end
            PC_EXC_HOLD: begin
                stall_d     = STALL_MEM;
                state_d     = PC_FLUSH;
                flush_cnt_d = FLUSH_LAST;
            end
            PC_FLUSH: begin
                if (flush_cnt_q == 3'd0)
                    state_d = PC_RUN;
                else
                    flush_cnt_d = flush_cnt_q - 3'd1;
            end
            default: state_d = PC_RUN;
        endcase
        flush_d = (state_d == PC_FLUSH);
    end

    assign stall_any = (stall_d != STALL_NONE);

    // Sticky: once the run counter saturates the flag stays until reset.
    assign stall_timeout_d = stall_timeout_q | wd_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= PC_RUN;
            flush_cnt_q     <= 3'd0;
            new_pc_q        <= ZERO_WORD;
            flush_q         <= 1'b0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            new_pc_q        <= new_pc_d;
            flush_q         <= flush_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    sat_counter #(
        .W   (WD_W),
        .MAX (WD_MAX)
    ) u_wd_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any),
        .clr   (!stall_any),
        .count (wd_count),
        .sat   (wd_sat)
    );

    sat_counter #(
        .W   (32),
        .MAX (32'hFFFF_FFFF)
    ) u_cycles_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any && !cycles_sat),
        .clr   (1'b0),
        .count (cycles_count),
        .sat   (cycles_sat)
    );

    assign bus.stall         = stall_d;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_timeout = stall_timeout_q | wd_sat;
    assign bus.stall_cycles  = cycles_count;

    logic unused_wd;
    assign unused_wd = ^wd_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table on a FLUSH_CYCLES=1
// instance, then hand sequences on a FLUSH_CYCLES=3 instance.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    pipe_ctrl_if ifa ();
    pipe_ctrl_if ifb ();

    pipe_ctrl #(
        .EXC_VECTOR    (32'h0000_0020),
        .FLUSH_CYCLES  (1),
        .STALL_TIMEOUT (8)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    pipe_ctrl #(
        .EXC_VECTOR    (32'h0000_0020),
        .FLUSH_CYCLES  (3),
        .STALL_TIMEOUT (8)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        id;
        logic        ex;
        logic        mem;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  stall;
        logic        flush;
        logic        chk_npc;
        logic [31:0] npc;
        logic [31:0] cyc;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic [31:0] exc, input logic [31:0] epc);
        ifa.stallreq_id  = id;  ifb.stallreq_id  = id;
        ifa.stallreq_ex  = ex;  ifb.stallreq_ex  = ex;
        ifa.stallreq_mem = mem; ifb.stallreq_mem = mem;
        ifa.excepttype_i = exc; ifb.excepttype_i = exc;
        ifa.cp0_epc_i    = epc; ifb.cp0_epc_i    = epc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic id, input logic ex, input logic mem,
                           input logic [31:0] exc, input logic [31:0] epc,
                           input logic [5:0] stall, input logic flush,
                           input logic chk_npc, input logic [31:0] npc,
                           input logic [31:0] cyc);
        vecs[i].id = id; vecs[i].ex = ex; vecs[i].mem = mem;
        vecs[i].exc = exc; vecs[i].epc = epc;
        vecs[i].stall = stall; vecs[i].flush = flush;
        vecs[i].chk_npc = chk_npc; vecs[i].npc = npc; vecs[i].cyc = cyc;
    endtask

    initial begin
        // One entry per cycle; stall_cycles is the count of earlier stalled cycles.
        set_vec( 0, 0,0,0, 32'h0, 32'h0,    6'b000000, 0, 1, 32'h0,    0);
        set_vec( 1, 1,0,0, 32'h0, 32'h0,    6'b000111, 0, 1, 32'h0,    0);
        set_vec( 2, 0,0,0, 32'h0, 32'h0,    6'b000000, 0, 1, 32'h0,    1);
        set_vec( 3, 1,1,1, 32'h0, 32'h0,    6'b011111, 0, 0, 32'h0,    1);
        set_vec( 4, 1,1,0, 32'h0, 32'h0,    6'b001111, 0, 0, 32'h0,    2);
        set_vec( 5, 1,0,0, 32'h0, 32'h0,    6'b000111, 0, 0, 32'h0,    3);
        set_vec( 6, 0,1,0, 32'h8, 32'h0,    6'b011111, 0, 1, 32'h0,    4);
        set_vec( 7, 0,1,0, 32'h0, 32'h0,    6'b000000, 1, 1, 32'h20,   5);
        set_vec( 8, 0,0,0, 32'h0, 32'h0,    6'b000000, 0, 0, 32'h0,    5);
        set_vec( 9, 1,0,0, 32'he, 32'h1234, 6'b011111, 0, 0, 32'h0,    5);
        set_vec(10, 0,0,1, 32'h0, 32'h5678, 6'b000000, 1, 1, 32'h1234, 6);
        set_vec(11, 0,0,0, 32'h0, 32'h0,    6'b000000, 0, 0, 32'h0,    6);
        set_vec(12, 0,1,0, 32'h0, 32'h0,    6'b001111, 0, 0, 32'h0,    6);
        set_vec(13, 0,0,0, 32'h0, 32'h0,    6'b000000, 0, 0, 32'h0,    7);

        drive(0, 0, 0, 32'h0, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (i > 0) next_cycle();
            drive(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].epc);
            @(negedge clk);
            chk($sformatf("a_stall[%0d]", i), {26'd0, ifa.stall}, {26'd0, vecs[i].stall});
            chk($sformatf("a_flush[%0d]", i), {31'd0, ifa.flush}, {31'd0, vecs[i].flush});
            chk($sformatf("a_cycles[%0d]", i), ifa.stall_cycles, vecs[i].cyc);
            chk($sformatf("a_timeout[%0d]", i), {31'd0, ifa.stall_timeout}, 32'd0);
            if (vecs[i].chk_npc)
                chk($sformatf("a_new_pc[%0d]", i), ifa.new_pc, vecs[i].npc);
        end

        // ERET with a 3-cycle flush: new_pc must ignore cp0_epc_i changes.
        next_cycle();
        rst_b = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b_rst_stall", {26'd0, ifb.stall}, 32'd0);
        chk("b_rst_flush", {31'd0, ifb.flush}, 32'd0);
        chk("b_rst_new_pc", ifb.new_pc, 32'd0);
        chk("b_rst_cycles", ifb.stall_cycles, 32'd0);
        chk("b_rst_timeout", {31'd0, ifb.stall_timeout}, 32'd0);

        next_cycle();
        drive(0, 0, 0, 32'he, 32'h1234);
        @(negedge clk);
        chk("b_eret_stall", {26'd0, ifb.stall}, {26'd0, 6'b011111});
        chk("b_eret_flush0", {31'd0, ifb.flush}, 32'd0);

        next_cycle();
        drive(1, 0, 0, 32'h0, 32'hAAAA);
        @(negedge clk);
        chk("b_flush1", {31'd0, ifb.flush}, 32'd1);
        chk("b_flush1_new_pc", ifb.new_pc, 32'h1234);
        chk("b_flush1_stall", {26'd0, ifb.stall}, 32'd0);

        next_cycle();
        drive(0, 0, 0, 32'h8, 32'hBBBB);
        @(negedge clk);
        chk("b_flush2", {31'd0, ifb.flush}, 32'd1);
        chk("b_flush2_new_pc", ifb.new_pc, 32'h1234);
        chk("b_flush2_stall", {26'd0, ifb.stall}, 32'd0);

        next_cycle();
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b_flush3", {31'd0, ifb.flush}, 32'd1);
        chk("b_flush3_new_pc", ifb.new_pc, 32'h1234);

        next_cycle();
        @(negedge clk);
        chk("b_flush_done", {31'd0, ifb.flush}, 32'd0);
        chk("b_flush_done_stall", {26'd0, ifb.stall}, 32'd0);
        chk("b_flush_done_cycles", ifb.stall_cycles, 32'd1);

        // Watchdog: 7 stalled cycles then a gap must not trip; 8 in a row must.
        next_cycle();
        rst_b = 1'b1;
        next_cycle();
        rst_b = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wd_rst_cycles", ifb.stall_cycles, 32'd0);

        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            drive(0, 0, 1, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("wd_pre_timeout[%0d]", k), {31'd0, ifb.stall_timeout}, 32'd0);
        end
        next_cycle();
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wd_gap_timeout", {31'd0, ifb.stall_timeout}, 32'd0);

        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            drive(0, 0, 1, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("wd_run_stall[%0d]", k), {26'd0, ifb.stall}, {26'd0, 6'b011111});
            chk($sformatf("wd_run_timeout[%0d]", k), {31'd0, ifb.stall_timeout}, 32'd0);
        end
        next_cycle();
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wd_set", {31'd0, ifb.stall_timeout}, 32'd1);
        chk("wd_cycles", ifb.stall_cycles, 32'd15);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("wd_sticky", {31'd0, ifb.stall_timeout}, 32'd1);

        // Reset in the middle of a 3-cycle flush.
        next_cycle();
        drive(0, 0, 0, 32'h8, 32'h0);
        @(negedge clk);
        chk("rf_exc_stall", {26'd0, ifb.stall}, {26'd0, 6'b011111});
        next_cycle();
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rf_flush", {31'd0, ifb.flush}, 32'd1);
        chk("rf_new_pc", ifb.new_pc, 32'h20);
        chk("rf_cycles", ifb.stall_cycles, 32'd16);
        next_cycle();
        rst_b = 1'b1;
        @(negedge clk);
        chk("rf_flush_before_rst", {31'd0, ifb.flush}, 32'd1);
        next_cycle();
        rst_b = 1'b0;
        @(negedge clk);
        chk("rf_after_flush", {31'd0, ifb.flush}, 32'd0);
        chk("rf_after_stall", {26'd0, ifb.stall}, 32'd0);
        chk("rf_after_new_pc", ifb.new_pc, 32'd0);
        chk("rf_after_cycles", ifb.stall_cycles, 32'd0);
        chk("rf_after_timeout", {31'd0, ifb.stall_timeout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
